// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the instruction-memory boot loader: the loader
//   state encoding and the instruction RAM geometry. The RAM and the chip
//   top use the same constants.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W  = 7;
    localparam int IMEM_DEPTH   = 128;
    localparam int IMEM_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer
//   Packs accepted stream bytes little-endian into a 32-bit word and keeps
//   a running 8-bit sum of every packed byte.
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : restart packing at lane 0 with a zero sum
//   accept     : data is taken this cycle
//   data       : stream byte
//   w_inst     : word being assembled (lane 0 = bits [7:0])
//   sum        : running sum of packed bytes, mod 256
//   word_full  : this accept fills lane 3, completing the word
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [31:0] w_inst,
    output logic [7:0]  sum,
    output logic        word_full
);

    logic [1:0] byte_idx;

    assign word_full = accept && (byte_idx == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx <= '0;
            w_inst   <= '0;
            sum      <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            sum      <= '0;
        end else if (accept) begin
            case (byte_idx)
                2'd0:    w_inst[7:0]   <= data;
                2'd1:    w_inst[15:8]  <= data;
                2'd2:    w_inst[23:16] <= data;
                default: w_inst[31:24] <= data;
            endcase
            sum      <= sum + data;
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time loader: receives a byte stream, writes 32-bit words to the
//   instruction RAM at sequential addresses, then verifies a trailing
//   checksum byte. iwen holds the core stalled while loading and on error.
//   clk, rst        : clock, asynchronous active-low reset
//   start, abort    : begin a load (pulse) / force failure (level)
//   word_count      : words to load, latched on start
//   byte_valid/data : stream input; byte_ready is the loader's handshake
//   iwen            : core stall / instruction-load enable
//   i_addr, w_inst, mem_we : instruction RAM write port
//   busy, done, err : status (done and err are sticky until the next start)
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RECV  | packing stream bytes into the current word
//   WRITE | one-cycle RAM write of the assembled word
//   CSUM  | waiting for the trailing checksum byte
//   DONE  | load good, core released
//   ERR   | load failed, core held stalled
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W  = IMEM_ADDR_W,
    parameter int DEPTH   = IMEM_DEPTH,
    parameter int TIMEOUT = IMEM_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              iwen,
    output logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       w_inst,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]  DEPTH_V  = (ADDR_W + 1)'(DEPTH);

    state_t              state, state_next;
    logic [ADDR_W:0]     count;
    logic [ADDR_W-1:0]   word_idx;
    logic [TMR_W-1:0]    timer;
    logic [7:0]          sum;
    logic [7:0]          sum_final;
    logic                handshake, accept, pack_accept, word_full;
    logic                start_ok, count_bad, last_word, tmo_hit;

    assign byte_ready  = (state == ST_RECV) || (state == ST_CSUM);
    assign busy        = (state == ST_RECV) || (state == ST_WRITE) || (state == ST_CSUM);
    assign mem_we      = (state == ST_WRITE);
    assign i_addr      = word_idx;

    assign handshake   = byte_valid && byte_ready;
    // An abort on the accept cycle discards the byte.
    assign accept      = handshake && !abort;
    assign pack_accept = accept && (state == ST_RECV);
    assign start_ok    = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign count_bad   = (word_count == '0) || (word_count > DEPTH_V);
    assign last_word   = ({1'b0, word_idx} == (count - 1'b1));
    assign tmo_hit     = (timer == TMR_LAST) && !handshake;
    assign sum_final   = sum + byte_data;

    imem_loader_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .accept    (pack_accept),
        .data      (byte_data),
        .w_inst    (w_inst),
        .sum       (sum),
        .word_full (word_full)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_next = count_bad ? ST_ERR : ST_RECV;
            end
            ST_RECV: begin
                if (abort)          state_next = ST_ERR;
                else if (tmo_hit)   state_next = ST_ERR;
                else if (word_full) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (abort)          state_next = ST_ERR;
                else if (last_word) state_next = ST_CSUM;
                else                state_next = ST_RECV;
            end
            ST_CSUM: begin
                if (abort)          state_next = ST_ERR;
                else if (tmo_hit)   state_next = ST_ERR;
                else if (accept)    state_next = (sum_final == 8'd0) ? ST_DONE : ST_ERR;
            end
            default:                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            iwen     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            count    <= '0;
            word_idx <= '0;
            timer    <= '0;
        end else begin
            state <= state_next;
            // Status flags track the state being entered, so they are sticky
            // for as long as DONE/ERR is held.
            iwen  <= (state_next == ST_RECV) || (state_next == ST_WRITE) ||
                     (state_next == ST_CSUM) || (state_next == ST_ERR);
            done  <= (state_next == ST_DONE);
            err   <= (state_next == ST_ERR);

            if (start_ok && !count_bad) begin
                count    <= word_count;
                word_idx <= '0;
            end else if ((state == ST_WRITE) && !abort && !last_word) begin
                word_idx <= word_idx + 1'b1;
            end

            if (start_ok || handshake || (state == ST_WRITE))
                timer <= '0;
            else if ((state == ST_RECV) || (state == ST_CSUM))
                timer <= timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int TMO   = 16;
    localparam int DEPTH = 128;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        iwen;
    logic [6:0]  i_addr;
    logic [31:0] w_inst;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.ADDR_W(7), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .iwen       (iwen),
        .i_addr     (i_addr),
        .w_inst     (w_inst),
        .mem_we     (mem_we),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write log of the RAM port, sampled mid-cycle.
    logic [6:0]  wa[$];
    logic [31:0] wd[$];
    always @(negedge clk) begin
        if (rst && mem_we) begin
            wa.push_back(i_addr);
            wd.push_back(w_inst);
        end
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] pre[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one load and checks it against the stream-level model: words are
    // bytes taken four at a time little-endian, checksum makes the byte sum
    // zero mod 256, a clean stream finishes 5n+1 cycles after start.
    task automatic run_load(input int n, input bit bad, input int gap_at, input int gap_len,
                            input int abort_at, input int stop_after, input int start_mid,
                            input string tag);
        logic [7:0] b[$];
        logic [7:0] s, csum, v;
        int  t0, tmo, fail, nexp, wbad, exp_cyc;
        bit  legal, exp_ok, gap_bad, stopped;
        legal = (n >= 1) && (n <= DEPTH);
        s = 8'd0;
        b.delete();
        if (legal) begin
            for (int i = 0; i < 4 * n; i++) begin
                if (pre.size() > 0) v = pre.pop_front();
                else v = 8'($urandom_range(0, 255));
                b.push_back(v);
                s = s + v;
            end
            csum = 8'd0 - s;
            if (bad) csum = (csum == 8'd0) ? 8'h01 : 8'h00;
            b.push_back(csum);
        end
        wa.delete();
        wd.delete();
        fail = -1;
        gap_bad = 1'b0;
        stopped = 1'b0;

        start = 1'b1;
        word_count = 8'(n);
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;

        for (int i = 0; i < b.size(); i++) begin
            if (i == stop_after) begin
                stopped = 1'b1;
                break;
            end
            if (i == gap_at) begin
                byte_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    if (gap_len < TMO && (!byte_ready || mem_we)) gap_bad = 1'b1;
                end
                if (gap_len >= TMO) begin
                    fail = i;
                    break;
                end
            end
            byte_valid = 1'b1;
            byte_data = b[i];
            tmo = 0;
            while (!byte_ready && tmo < 20) begin
                @(negedge clk);
                tmo++;
            end
            if (i == abort_at) abort = 1'b1;
            if (i == start_mid) begin
                start = 1'b1;
                word_count = 8'd1;
            end
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            if (i == abort_at) begin
                fail = i;
                break;
            end
        end
        byte_valid = 1'b0;
        if (stopped) return;

        tmo = 0;
        while (!(done || err) && tmo < 64) begin
            @(negedge clk);
            tmo++;
        end

        exp_ok = legal && !bad && (fail < 0);
        nexp = !legal ? 0 : ((fail < 0) ? n : fail / 4);
        check({tag, ".done"}, 64'(done), 64'(exp_ok));
        check({tag, ".err"},  64'(err),  64'(!exp_ok));
        check({tag, ".iwen"}, 64'(iwen), 64'(!exp_ok));
        check({tag, ".busy"}, 64'(busy), 64'(0));
        check({tag, ".nwr"},  64'(wa.size()), 64'(nexp));
        wbad = 0;
        for (int k = 0; k < wa.size() && k < nexp; k++) begin
            if (wa[k] !== 7'(k) || wd[k] !== {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]}) wbad++;
        end
        check({tag, ".words"}, 64'(wbad), 64'(0));
        if (gap_len == 0 && fail < 0) begin
            exp_cyc = legal ? 5 * n + 1 : 0;
            check({tag, ".cycles"}, 64'(cyc - t0), 64'(exp_cyc));
        end
        if (gap_len > 0 && gap_len < TMO)
            check({tag, ".stall"}, 64'(gap_bad), 64'(0));
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        word_count = 8'd0;
        byte_valid = 1'b0;
        byte_data = 8'd0;
        #3;
        check("reset", {byte_ready, iwen, mem_we, busy, done, err, i_addr, w_inst}, 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        pre = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(2, 1'b0, -1, 0, -1, -1, -1, "happy");
        check("happy.w0", 64'(wd.size() > 0 ? wd[0] : 32'hx), 64'(32'h00000013));
        check("happy.w1", 64'(wd.size() > 1 ? wd[1] : 32'hx), 64'(32'h00100093));

        pre = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(2, 1'b1, -1, 0, -1, -1, -1, "badsum");

        run_load(3, 1'b0, 5, 10, -1, -1, -1, "stall");
        run_load(2, 1'b0, 2, TMO, -1, -1, -1, "timeout");
        run_load(0, 1'b0, -1, 0, -1, -1, -1, "cnt0");
        run_load(129, 1'b0, -1, 0, -1, -1, -1, "cnt129");
        run_load(2, 1'b0, -1, 0, 2, -1, -1, "abort");
        run_load(4, 1'b0, -1, 0, -1, -1, -1, "after_abort");

        for (int r = 0; r < 6; r++)
            run_load(int'($urandom_range(1, 8)), ($urandom_range(0, 3) == 0), -1, 0, -1, -1, -1, "rand");

        run_load(DEPTH, 1'b0, -1, 0, -1, -1, -1, "full");
        run_load(3, 1'b0, -1, 0, -1, -1, 5, "start_busy");

        run_load(2, 1'b0, -1, 0, -1, 4, -1, "rst_mid");
        check("rst_mid.inwrite", 64'(mem_we), 64'(1));
        #1 rst = 1'b0;
        #1;
        check("rst_mid.async", {byte_ready, iwen, mem_we, busy, done, err, i_addr, w_inst}, 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_load(3, 1'b0, -1, 0, -1, -1, -1, "recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
